// File: rtl/alu_muldiv_seq.sv
// -----------------------------------------------------------------------------
// alu_muldiv_seq
// Multi-cycle unsigned MUL / DIVU / REMU sequencer that borrows the shared
// 32-bit single-cycle ALU, one ALU operation per clock. The block itself holds
// only shift registers, a bit counter and a few flags; every add, subtract and
// compare happens in the external ALU.
//
// Ports
//   clk_i          clock, all state changes on the rising edge
//   rst_i          synchronous active-high reset
//   start_i        request, sampled only while busy_o = 0
//   op_i[1:0]      00 MUL (low word), 01 DIVU, 10 REMU, 11 illegal
//   a_i[31:0]      multiplicand / dividend, sampled with start_i
//   b_i[31:0]      multiplier / divisor, sampled with start_i
//   busy_o         operation in flight
//   done_o         one-cycle pulse, result_o valid in that cycle
//   result_o[31:0] final value, held until replaced or reset
//   alu_req_o      this block owns the ALU this cycle
//   alu_x_o/alu_y_o[31:0], alu_ctrl_o[4:0]  ALU operands and control
//   alu_result_i[31:0], alu_zero_i          ALU outputs (same cycle)
// -----------------------------------------------------------------------------
module alu_muldiv_seq #(
  parameter logic [4:0] ALU_ADD  = 5'd2,
  parameter logic [4:0] ALU_SUB  = 5'd3,
  parameter logic [4:0] ALU_SLTU = 5'd6
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [1:0]  op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] result_o,
  output logic        alu_req_o,
  output logic [31:0] alu_x_o,
  output logic [31:0] alu_y_o,
  output logic [4:0]  alu_ctrl_o,
  input  logic [31:0] alu_result_i,
  input  logic        alu_zero_i
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_MUL     = 3'd1,
    S_DIV_CMP = 3'd2,
    S_DIV_SUB = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  localparam logic [1:0] OP_MUL  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_ILL  = 2'b11;

  state_t      state_q, state_d;
  logic [31:0] acc_q, acc_d;       // MUL: running sum; DIV: partial remainder
  logic [31:0] mcand_q, mcand_d;   // MUL: shifted multiplicand; DIV: dividend
  logic [31:0] mplier_q, mplier_d; // MUL: shifted multiplier; DIV: quotient
  logic [31:0] b_q, b_d;           // latched divisor
  logic [4:0]  cnt_q, cnt_d;
  logic        lt_q, lt_d;
  logic        msb_q, msb_d;
  logic [1:0]  op_q, op_d;
  logic [31:0] result_q, result_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [31:0] rem_sh_s;
  logic        skip_s;

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      acc_q    <= 32'd0;
      mcand_q  <= 32'd0;
      mplier_q <= 32'd0;
      b_q      <= 32'd0;
      cnt_q    <= 5'd0;
      lt_q     <= 1'b0;
      msb_q    <= 1'b0;
      op_q     <= 2'b00;
      result_q <= 32'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      b_q      <= b_d;
      cnt_q    <= cnt_d;
      lt_q     <= lt_d;
      msb_q    <= msb_d;
      op_q     <= op_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // Next-state, datapath update and ALU drive
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    mcand_d    = mcand_q;
    mplier_d   = mplier_q;
    b_d        = b_q;
    cnt_d      = cnt_q;
    lt_d       = lt_q;
    msb_d      = msb_q;
    op_d       = op_q;
    result_d   = result_q;
    alu_req_o  = 1'b0;
    alu_x_o    = 32'd0;
    alu_y_o    = 32'd0;
    alu_ctrl_o = 5'd0;
    rem_sh_s   = {acc_q[30:0], mcand_q[31]};
    // A set msb means the real shifted remainder is >= 2^32 > b, so the
    // raw compare is overridden and the subtract always happens.
    skip_s     = lt_q & ~msb_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          op_d  = op_i;
          b_d   = b_i;
          cnt_d = 5'd0;
          if (op_i == OP_ILL) begin
            result_d = 32'd0;
            state_d  = S_DONE;
          end else if (op_i == OP_MUL) begin
            acc_d    = 32'd0;
            mcand_d  = a_i;
            mplier_d = b_i;
            state_d  = S_MUL;
          end else if (b_i == 32'd0) begin
            result_d = (op_i == OP_DIVU) ? 32'hFFFF_FFFF : a_i;
            state_d  = S_DONE;
          end else begin
            acc_d    = 32'd0;
            mcand_d  = a_i;
            mplier_d = 32'd0;
            state_d  = S_DIV_CMP;
          end
        end else begin
          state_d = S_IDLE;
        end
      end

      S_MUL: begin
        alu_req_o  = 1'b1;
        alu_x_o    = acc_q;
        alu_y_o    = mplier_q[0] ? mcand_q : 32'd0;
        alu_ctrl_o = ALU_ADD;
        acc_d      = alu_result_i;
        mcand_d    = {mcand_q[30:0], 1'b0};
        mplier_d   = {1'b0, mplier_q[31:1]};
        cnt_d      = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          result_d = alu_result_i;
          state_d  = S_DONE;
        end else begin
          state_d = S_MUL;
        end
      end

      S_DIV_CMP: begin
        alu_req_o  = 1'b1;
        alu_x_o    = rem_sh_s;
        alu_y_o    = b_q;
        alu_ctrl_o = ALU_SLTU;
        msb_d      = acc_q[31];
        acc_d      = rem_sh_s;
        mcand_d    = {mcand_q[30:0], 1'b0};
        lt_d       = ~alu_zero_i;
        state_d    = S_DIV_SUB;
      end

      S_DIV_SUB: begin
        alu_req_o  = 1'b1;
        alu_x_o    = acc_q;
        alu_y_o    = skip_s ? 32'd0 : b_q;
        alu_ctrl_o = ALU_SUB;
        acc_d      = alu_result_i;
        mplier_d   = {mplier_q[30:0], ~skip_s};
        cnt_d      = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          result_d = (op_q == OP_DIVU) ? {mplier_q[30:0], ~skip_s} : alu_result_i;
          state_d  = S_DONE;
        end else begin
          state_d = S_DIV_CMP;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d == S_MUL) || (state_d == S_DIV_CMP) || (state_d == S_DIV_SUB);
    done_d = (state_d == S_DONE);
  end

  assign busy_o   = busy_q;
  assign done_o   = done_q;
  assign result_o = result_q;

endmodule

// File: tb/tb_alu_muldiv_seq.sv
module tb_alu_muldiv_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a, b;
  logic        busy, done, alu_req, alu_zero;
  logic [31:0] result, alu_x, alu_y, alu_res;
  logic [4:0]  alu_ctrl;

  int checks = 0;
  int errors = 0;

  alu_muldiv_seq dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .op_i(op), .a_i(a), .b_i(b),
    .busy_o(busy), .done_o(done), .result_o(result),
    .alu_req_o(alu_req), .alu_x_o(alu_x), .alu_y_o(alu_y), .alu_ctrl_o(alu_ctrl),
    .alu_result_i(alu_res), .alu_zero_i(alu_zero)
  );

  always #5 clk = ~clk;

  // The shared single-cycle ALU that sits in the EX stage
  always_comb begin
    case (alu_ctrl)
      5'd2:    alu_res = alu_x + alu_y;
      5'd3:    alu_res = alu_x - alu_y;
      5'd6:    alu_res = {31'd0, (alu_x < alu_y)};
      default: alu_res = 32'd0;
    endcase
  end
  assign alu_zero = (alu_res == 32'd0);

  // Architectural result of one request
  function automatic logic [31:0] ref_res(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    logic [63:0] p;
    case (o)
      2'b00: begin p = 64'(x) * 64'(y); ref_res = p[31:0]; end
      2'b01: ref_res = (y == 32'd0) ? 32'hFFFF_FFFF : x / y;
      2'b10: ref_res = (y == 32'd0) ? x : x % y;
      default: ref_res = 32'd0;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, got, want);
    end
  endtask

  // Transaction-level model: remaining-cycles counter plus pending result
  int          m_left = 0;
  logic        m_busy = 1'b0;
  logic        m_done = 1'b0;
  logic [31:0] m_res  = 32'd0;
  logic [31:0] m_pend = 32'd0;

  always @(posedge clk) begin
    if (rst) begin
      m_left <= 0; m_busy <= 1'b0; m_done <= 1'b0; m_res <= 32'd0;
    end else if (m_left != 0) begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_busy <= 1'b0; m_done <= 1'b1; m_res <= m_pend;
      end else begin
        m_done <= 1'b0;
      end
    end else if (start) begin
      m_pend <= ref_res(op, a, b);
      if (op == 2'b11 || (op != 2'b00 && b == 32'd0)) begin
        m_done <= 1'b1; m_res <= ref_res(op, a, b);
      end else begin
        m_busy <= 1'b1; m_done <= 1'b0; m_left <= (op == 2'b00) ? 32 : 64;
      end
    end else begin
      m_done <= 1'b0;
    end
  end

  // Per-cycle comparison of DUT outputs against the model
  always @(negedge clk) begin
    chk("busy", 32'(busy), 32'(m_busy));
    chk("alu_req", 32'(alu_req), 32'(m_busy));
    chk("done", 32'(done), 32'(m_done));
    if (m_done) chk("result", result, m_res);
    if (!m_busy) begin
      chk("alu_x_idle", alu_x, 32'd0);
      chk("alu_y_idle", alu_y, 32'd0);
      chk("alu_ctrl_idle", 32'(alu_ctrl), 32'd0);
    end
  end

  // Issue one request at the current negedge and return at the negedge where
  // done is seen; a following call therefore starts in the DONE cycle.
  task automatic do_op(input string tag, input logic [1:0] o, input logic [31:0] x,
                       input logic [31:0] y, input logic [31:0] exp_res,
                       input int exp_lat, input bit noise);
    int n;
    int reqs;
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0; n = 1; reqs = 0;
    while (!done && n < 200) begin
      if (alu_req) reqs++;
      if (noise && $urandom_range(0, 5) == 0) begin
        start = 1'b1; op = 2'($urandom_range(0, 3)); a = $urandom; b = $urandom;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    if (!done) begin
      checks++; errors++;
      $display("FAIL %s timeout: no done within %0d cycles", tag, n);
    end else begin
      chk({tag, "_latency"}, 32'(n), 32'(exp_lat));
      chk({tag, "_alu_cycles"}, 32'(reqs), 32'(exp_lat - 1));
      chk({tag, "_result"}, result, exp_res);
    end
  endtask

  initial begin
    int ndone;
    logic [1:0]  ro;
    logic [31:0] ra, rb;
    int lat;

    rst = 1'b1; start = 1'b0; op = 2'b00; a = 32'd0; b = 32'd0;
    @(negedge clk); @(negedge clk);
    chk("reset_result", result, 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    rst = 1'b0;

    // Directed, hand-computed expectations (first start right after reset)
    do_op("mul7x6", 2'b00, 32'd7, 32'd6, 32'd42, 33, 1'b0);
    @(negedge clk);
    do_op("mul_ff", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 33, 1'b0);
    do_op("mul_wrap", 2'b00, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 33, 1'b0);
    do_op("divu100_7", 2'b01, 32'd100, 32'd7, 32'd14, 65, 1'b0);
    do_op("remu100_7", 2'b10, 32'd100, 32'd7, 32'd2, 65, 1'b0);
    do_op("divu_msb", 2'b01, 32'hFFFF_FFFF, 32'h8000_0001, 32'd1, 65, 1'b0);
    do_op("remu_msb", 2'b10, 32'hFFFF_FFFF, 32'h8000_0001, 32'h7FFF_FFFE, 65, 1'b0);
    do_op("divu_by0", 2'b01, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 1'b0);
    do_op("remu_by0", 2'b10, 32'd5, 32'd0, 32'd5, 1, 1'b0);
    do_op("illegal", 2'b11, 32'd9, 32'd3, 32'd0, 1, 1'b0);
    @(negedge clk);

    // New operands presented at T+10 of a MUL must be ignored
    start = 1'b1; op = 2'b00; a = 32'd1234; b = 32'd5678;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    start = 1'b1; op = 2'b01; a = 32'd99; b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    ndone = 0;
    while (!done && ndone < 100) begin @(negedge clk); ndone++; end
    chk("ignore_start_result", result, 32'd7006652);
    @(negedge clk);

    // Reset at T+10 of a MUL aborts it with no done
    start = 1'b1; op = 2'b00; a = 32'd3; b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_alu_req", 32'(alu_req), 32'd0);
    chk("abort_result", result, 32'd0);
    ndone = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("abort_no_done", 32'(ndone), 32'd0);

    // Randomized requests, with ignored start noise while busy
    repeat (40) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 20));
        default: rb = $urandom;
      endcase
      if (ro == 2'b11 || (ro != 2'b00 && rb == 32'd0)) lat = 1;
      else if (ro == 2'b00) lat = 33;
      else lat = 65;
      do_op("rand", ro, ra, rb, ref_res(ro, ra, rb), lat, 1'b1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_muldiv_seq.md
# alu_muldiv_seq

Multi-cycle sequencer that runs RV32M-style unsigned multiply, divide and remainder on the existing 32-bit single-cycle ALU, one ALU operation per clock. It sits beside the EX stage. While `alu_req` is high it owns the shared ALU: the EX-stage operand mux selects `alu_x`, `alu_y` and `alu_ctrl` from this block, and this block reads `alu_result` and `alu_zero` back. The block adds no adder or comparator of its own; it keeps only shift registers and a counter.

## Interface
- `ALU_ADD`, default 5'd2, ALU control code for add.
- `ALU_SUB`, default 5'd3, ALU control code for subtract.
- `ALU_SLTU`, default 5'd6, ALU control code for unsigned set-less-than.
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request; sampled only while `busy`=0.
- `op`  in  2  operation: 00 MUL (low 32 bits of the product), 01 DIVU, 10 REMU, 11 illegal.
- `a`  in  32  multiplicand or dividend; sampled with `start`.
- `b`  in  32  multiplier or divisor; sampled with `start`.
- `busy`  out  1  high while an operation is in flight.
- `done`  out  1  one-cycle pulse; `result` is valid in that cycle.
- `result`  out  32  final value; held until the next accepted `start` or `rst`.
- `alu_req`  out  1  high while this block drives the ALU.
- `alu_x`, `alu_y`  out  32  ALU operands.
- `alu_ctrl`  out  5  ALU control code.
- `alu_result`  in  32  ALU output.
- `alu_zero`  in  1  ALU zero flag.

## Operation
- States:
  - IDLE.
  - MUL.
  - DIV_CMP.
  - DIV_SUB.
  - DONE.
- Internal registers:
  - `acc`/`rem` (32 bits).
  - `mcand`/`dvd` (32 bits).
  - `mplier`/`q` (32 bits).
  - 5-bit iteration counter `cnt`.
  - `lt` flag.
  - `msb` flag.
  - latched `op`.
- IDLE or DONE with `start`=1 leads to one of:
  - op=11: go to DONE and set result=0.
  - op=01 or 10 with b=0: go to DONE with no ALU use. DIVU sets result=0xFFFFFFFF; REMU sets result=a.
  - op=00: load acc=0, mcand=a, mplier=b, cnt=0, then go to MUL.
  - op=01 or 10 with b≠0: load rem=0, dvd=a, q=0, cnt=0, then go to DIV_CMP.
- MUL, one cycle per bit:
  - ALU drive: `alu_x`=acc, `alu_y`=(mplier[0] ? mcand : 0), `alu_ctrl`=ALU_ADD.
  - Updates: acc←alu_result, mcand←mcand<<1, mplier←mplier>>1, cnt←cnt+1.
  - After cnt=31: result←the final sum, then go to DONE.
  - All arithmetic is modulo 2^32.
- DIV_CMP (restoring division, dividend bit 31 first):
  - rem_sh={rem[30:0], dvd[31]}. The bit shifted out, rem[31], goes to `msb`.
  - ALU drive: `alu_x`=rem_sh, `alu_y`=b, `alu_ctrl`=ALU_SLTU.
  - Updates: rem←rem_sh, dvd←dvd<<1, lt←(~alu_zero & ~rem[31]). When msb=1 the true remainder is ≥2^32>b, so lt is forced to 0.
  - Go to DIV_SUB.
- DIV_SUB:
  - ALU drive: `alu_x`=rem, `alu_y`=(lt ? 0 : b), `alu_ctrl`=ALU_SUB.
  - Updates: rem←alu_result, q←{q[30:0], ~lt}. The 32-bit subtraction wraps and the true value is always <b.
  - cnt←cnt+1.
  - After cnt=31: result←(op=DIVU ? final q : final rem), then go to DONE; otherwise go back to DIV_CMP.
- DONE: `done`=1 and `busy`=0. With no `start`, go to IDLE next cycle. A `start` in DONE is accepted exactly as in IDLE.
- `start` while `busy`=1 is ignored; the operands are not re-sampled.
- Outside MUL, DIV_CMP and DIV_SUB: `alu_req`=0, `alu_x`=0, `alu_y`=0, `alu_ctrl`=0.
- Reset values: state=IDLE; `busy`=0, `done`=0, `result`=0, `alu_req`=0, ALU outputs 0; all internal registers 0.

## Timing
- Start is accepted at the edge ending cycle T.
- Latency to `done`:
  - MUL: `busy` and `alu_req` are high for cycles T+1..T+32; `done` is high in cycle T+33.
  - DIVU/REMU: `alu_req` is high for cycles T+1..T+64 (64 cycles, fixed and independent of data); `done` is high in cycle T+65.
  - Divide by zero and illegal op: `done` is high in cycle T+1; `busy` and `alu_req` stay 0.
- `result` updates at the same edge that raises `done`.
- ALU path is combinational: outputs are driven, `alu_result` is sampled at the end of the same cycle.
- `rst` asserted in any cycle, including mid-operation, returns all outputs to their reset values in the next cycle. The aborted operation produces no `done`. A `start` in the first cycle after `rst` deasserts is accepted.

## Test plan
- MUL: a=7, b=6 -> `done` at T+33, result=42, `alu_req` high exactly 32 cycles.
- MUL wrap cases: 0xFFFFFFFF×0xFFFFFFFF -> result=0x00000001; 0x00010000×0x00010000 -> result=0x00000000.
- Divide: DIVU 100/7 -> result=14 at T+65; REMU 100/7 -> result=2.
- 33-bit path (msb=1): DIVU 0xFFFFFFFF/0x80000001 -> result=1; REMU -> result=0x7FFFFFFE.
- Zero and illegal cases: DIVU 5/0 -> result=0xFFFFFFFF at T+1; REMU 5/0 -> result=5; op=11 -> result=0. In all three, `busy` and `alu_req` never assert.
- Control cases:
  - `start` with new operands at cycle T+10 of a MUL is ignored; the original product is returned.
  - `rst` at T+10 -> IDLE next cycle with all outputs 0 and no `done`.
  - Back-to-back `start` in the DONE cycle -> second operation completes with correct latency.
